delay_line_var: RTL

// - Parametrised pipeline delay line with valid tracking, stall and flush.
// - Generalises the fixed-depth shift_N family. The delay is selected at run time
//   (1..MAX_DEPTH cycles of en), so one instance aligns datapath operands
//   (e.g. butterfly inputs against twiddle/multiplier latency) in the NTT/arith pipelines.

---
 rtl/delay_line_var_if.sv | 58 +++++
 rtl/delay_line_var.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/delay_line_var_if.sv
// rtl/delay_line_var_if.sv - stream/control bundle for the variable-depth delay line
//
// Purpose:
//   Groups the pipeline control, input payload and tap outputs of delay_line_var
//   so that a producer/consumer can attach through a single port.
//
// Signals:
//   en         advance the pipeline one stage (0 = stall/hold)
//   flush      synchronous clear of every stage
//   delay_sel  requested delay in en-cycles, legal 1..MAX_DEPTH
//   in_valid   qualifier for in_data
//   in_data    payload entering stage 0
//   out_valid  valid bit of the selected tap
//   out_data   payload of the selected tap
//   sel_err    registered out-of-range flag for delay_sel
//   occupancy  count of valid entries held in all stages
//
// Modports:
//   master  drives control and input, observes the tap outputs
//   slave   the delay line itself
interface delay_line_var_if #(
   parameter int DATA_WIDTH = 24,
   parameter int SEL_W      = 5
);
   logic                  en;
   logic                  flush;
   logic [SEL_W-1:0]      delay_sel;
   logic                  in_valid;
   logic [DATA_WIDTH-1:0] in_data;
   logic                  out_valid;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  sel_err;
   logic [SEL_W-1:0]      occupancy;

   modport master (
      output en,
      output flush,
      output delay_sel,
      output in_valid,
      output in_data,
      input  out_valid,
      input  out_data,
      input  sel_err,
      input  occupancy
   );

   modport slave (
      input  en,
      input  flush,
      input  delay_sel,
      input  in_valid,
      input  in_data,
      output out_valid,
      output out_data,
      output sel_err,
      output occupancy
   );
endinterface

// File: rtl/delay_line_var.sv
// rtl/delay_line_var.sv - run-time selectable pipeline delay line with valid tracking
//
// Purpose:
//   MAX_DEPTH register stages, each holding {valid, data}. The stages advance
//   together on en and clear together on flush. The output is a combinational
//   tap onto stage[eff-1], where eff = clamp(delay_sel, 1, MAX_DEPTH), so a
//   sample accepted on one en-edge shows up eff en-cycles later. Stalled cycles
//   do not count toward the delay.
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   bus        delay_line_var_if.slave:
//                en, flush, delay_sel, in_valid, in_data   (in)
//                out_valid, out_data, sel_err, occupancy   (out)
//
// Configuration:
//   DLY_OCC_CNT_EN  when defined, occupancy is an up/down counter of valid
//                   entries in all stages; otherwise occupancy is tied to 0.
module delay_line_var #(
   parameter int DATA_WIDTH = 24,
   parameter int MAX_DEPTH  = 16,
   parameter int SEL_W      = 5
) (
   input logic              clk,
   input logic              rst,
   delay_line_var_if.slave  bus
);

   localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(MAX_DEPTH);

   // ------------------------------------------------------------------
   // Stage storage
   // ------------------------------------------------------------------
   logic                  stage_v_q   [MAX_DEPTH];
   logic                  stage_v_d   [MAX_DEPTH];
   logic [DATA_WIDTH-1:0] stage_dat_q [MAX_DEPTH];
   logic [DATA_WIDTH-1:0] stage_dat_d [MAX_DEPTH];

   logic                  sel_err_q;
   logic                  sel_err_d;

   // Next-state for the shift register. flush wins over en; data is captured
   // even for invalid entries so the datapath has no enable on the d bits
   // beyond the stage-wide en.
   always_comb begin
      for (int i = 0; i < MAX_DEPTH; i++) begin
         stage_v_d[i]   = stage_v_q[i];
         stage_dat_d[i] = stage_dat_q[i];
      end
      if (bus.flush) begin
         for (int i = 0; i < MAX_DEPTH; i++) begin
            stage_v_d[i]   = 1'b0;
            stage_dat_d[i] = '0;
         end
      end else if (bus.en) begin
         stage_v_d[0]   = bus.in_valid;
         stage_dat_d[0] = bus.in_data;
         for (int i = 1; i < MAX_DEPTH; i++) begin
            stage_v_d[i]   = stage_v_q[i-1];
            stage_dat_d[i] = stage_dat_q[i-1];
         end
      end
   end

   // The range flag is sampled every edge, independent of en, so software can
   // see a bad delay_sel even while the pipeline is stalled.
   always_comb begin
      sel_err_d = (bus.delay_sel == '0) || (bus.delay_sel > MAX_SEL);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < MAX_DEPTH; i++) begin
            stage_v_q[i]   <= 1'b0;
            stage_dat_q[i] <= '0;
         end
         sel_err_q <= 1'b0;
      end else begin
         for (int i = 0; i < MAX_DEPTH; i++) begin
            stage_v_q[i]   <= stage_v_d[i];
            stage_dat_q[i] <= stage_dat_d[i];
         end
         sel_err_q <= sel_err_d;
      end
   end

   // ------------------------------------------------------------------
   // Tap selection
   // ------------------------------------------------------------------
   logic [SEL_W-1:0]      tap_idx;
   logic                  tap_valid;
   logic [DATA_WIDTH-1:0] tap_data;

   // Clamp to 1..MAX_DEPTH, then convert to a 0-based stage index.
   always_comb begin
      if (bus.delay_sel == '0) begin
         tap_idx = '0;
      end else if (bus.delay_sel > MAX_SEL) begin
         tap_idx = MAX_SEL - SEL_W'(1);
      end else begin
         tap_idx = bus.delay_sel - SEL_W'(1);
      end
   end

   // Compare-based mux keeps the index within the array bounds even though
   // tap_idx is wider than log2(MAX_DEPTH).
   always_comb begin
      tap_valid = 1'b0;
      tap_data  = '0;
      for (int i = 0; i < MAX_DEPTH; i++) begin
         if (tap_idx == SEL_W'(i)) begin
            tap_valid = stage_v_q[i];
            tap_data  = stage_dat_q[i];
         end
      end
   end

   assign bus.out_valid = tap_valid;
   assign bus.out_data  = tap_data;
   assign bus.sel_err   = sel_err_q;

   // ------------------------------------------------------------------
   // Occupancy
   // ------------------------------------------------------------------
`ifdef DLY_OCC_CNT_EN
   logic [SEL_W-1:0] occ_q;
   logic [SEL_W-1:0] occ_d;
   logic             occ_inc;
   logic             occ_dec;

   // An entry enters when a valid sample is shifted in and leaves when a
   // valid entry falls off the last stage; both on the same edge cancel.
   always_comb begin
      occ_inc = bus.en & bus.in_valid;
      occ_dec = bus.en & stage_v_q[MAX_DEPTH-1];
      occ_d   = occ_q;
      if (bus.flush) begin
         occ_d = '0;
      end else if (occ_inc && !occ_dec && (occ_q != MAX_SEL)) begin
         occ_d = occ_q + SEL_W'(1);
      end else if (occ_dec && !occ_inc && (occ_q != '0)) begin
         occ_d = occ_q - SEL_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign bus.occupancy = occ_q;
`else
   assign bus.occupancy = '0;
`endif

endmodule
